dcache_burst_adapter: RTL

DCACHE_BURST_ADAPTER -- requirements
Module: dcache_burst_adapter

---
 rtl/dcache_burst_adapter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/dcache_burst_adapter.sv
// Bridges a cacheline read/write request to a 64-bit burst memory interface.
// Optional read-return address checking is enabled by defining ADAPTER_ADDR_CHECK_EN.
module dcache_burst_adapter #(
  parameter int unsigned BEATS  = 4,
  parameter int unsigned LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       dfp_addr,
  input  logic              dfp_read,
  input  logic              dfp_write,
  input  logic [LINE_W-1:0] dfp_wdata,
  output logic [LINE_W-1:0] dfp_rdata,
  output logic              dfp_resp,
  output logic [31:0]       bmem_addr,
  output logic              bmem_read,
  output logic              bmem_write,
  output logic [63:0]       bmem_wdata,
  input  logic              bmem_ready,
  input  logic [31:0]       bmem_raddr,
  input  logic [63:0]       bmem_rdata,
  input  logic              bmem_rvalid,
  output logic              addr_err
);

  localparam int unsigned BEAT_W = 64;
  localparam int unsigned CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [31:0] ALIGN_MASK = ~32'h0000_001F;

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_BURST, DONE} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_inc;
  logic [LINE_W-1:0] line;
  logic [LINE_W-1:0] line_upd;

  // Line buffer with the current read beat merged in at slot cnt.
  always_comb begin
    cnt_inc  = cnt + CNT_W'(1);
    line_upd = line;
    line_upd[cnt*BEAT_W +: BEAT_W] = bmem_rdata;
  end

  // Transaction FSM; all interface outputs are registered alongside the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      line       <= '0;
      dfp_rdata  <= '0;
      dfp_resp   <= 1'b0;
      bmem_addr  <= '0;
      bmem_read  <= 1'b0;
      bmem_write <= 1'b0;
      bmem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (dfp_write) begin
            state      <= WR_BURST;
            bmem_addr  <= dfp_addr & ALIGN_MASK;
            cnt        <= '0;
            line       <= dfp_wdata;
            bmem_wdata <= dfp_wdata[BEAT_W-1:0];
            bmem_write <= 1'b1;
          end else if (dfp_read) begin
            state     <= RD_REQ;
            bmem_addr <= dfp_addr & ALIGN_MASK;
            cnt       <= '0;
            bmem_read <= 1'b1;
          end
        end
        RD_REQ: begin
          if (bmem_ready) begin
            state     <= RD_WAIT;
            bmem_read <= 1'b0;
          end
        end
        RD_WAIT: begin
          if (bmem_rvalid) begin
            line <= line_upd;
            if (cnt == LAST_BEAT) begin
              state     <= DONE;
              dfp_rdata <= line_upd;
              dfp_resp  <= 1'b1;
            end else begin
              cnt <= cnt_inc;
            end
          end
        end
        WR_BURST: begin
          if (bmem_ready) begin
            if (cnt == LAST_BEAT) begin
              state      <= DONE;
              bmem_write <= 1'b0;
              dfp_resp   <= 1'b1;
            end else begin
              cnt        <= cnt_inc;
              bmem_wdata <= line[cnt_inc*BEAT_W +: BEAT_W];
            end
          end
        end
        DONE: begin
          state    <= IDLE;
          dfp_resp <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ADAPTER_ADDR_CHECK_EN
  // Sticky flag: a returned beat tagged with an address other than the request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_err <= 1'b0;
    end else if (state == RD_WAIT && bmem_rvalid && bmem_raddr != bmem_addr) begin
      addr_err <= 1'b1;
    end
  end
`else
  logic unused_raddr;
  assign unused_raddr = ^bmem_raddr;
  assign addr_err     = 1'b0;
`endif

endmodule
